psum_deskew_drain: RTL and testbench
====================================

# psum_deskew_drain

Downstream drain stage for the weight-stationary systolic array. It sits directly below the last PE row and consumes that row's `out_sum` bus. It removes the one-cycle-per-column skew that the array imposes on partial sums and buffers complete, aligned result rows in a small FIFO. It then presents the rows to the writeback path over a valid/ready handshake, and flags any row lost to back-pressure.

## Interface

**Parameters**
- `data_width`, default 22: PE operand width. Each partial sum is `2*data_width` bits.
- `w_tile_column_size`, default 16: number of PE columns (C).
- `fifo_depth`, default 4: number of aligned rows buffered. Must be a power of two, ≥ 2.
- `m_rows`, default 8: rows per output tile, used for `tile_done`.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: **synchronous, active-high reset**.
- `in_valid`, in, 1: marks the column-0 partial sum of a new row at this edge.
- `in_sum`, in, 2*data_width*C: skewed partial sums. Column j occupies `[2*data_width*j +: 2*data_width]`.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts `out_data` when high with `out_valid`.
- `out_data`, out, 2*data_width*C: aligned row at the FIFO head. Same column packing as `in_sum`.
- `overflow`, out, 1: sticky. Set when a row is dropped.
- `tile_done`, out, 1: one-cycle pulse when the `m_rows`-th aligned row of a tile completes.
- `row_count`, out, clog2(m_rows) bits: aligned rows seen in the current tile.

## Operation

**Skew model.** A row whose column-0 sum is sampled with `in_valid` at edge E carries column j's sum at edge E+j.

**Deskew.**
- Column j passes through a (C-1-j)-stage register delay line; column C-1 is taken directly from `in_sum`.
- `in_valid` passes through a C-1-stage delay line producing `row_valid`.
- At edge E+C-1, all C columns and `row_valid` are aligned.
- Delay lines shift every cycle unconditionally; the array cannot be stalled.
- Column data shifts regardless of valid; only `row_valid` qualifies it.

**FIFO.**
- Circular buffer with `fifo_depth` entries: write pointer, read pointer, and an occupancy count from 0 to `fifo_depth`.
- Push when `row_valid`.
- Pop when `out_valid && out_ready`.
- Empty: `out_valid=0` and `out_data` is all zeros (gated, never stale).
- Non-empty: `out_data` is the head entry.
- Push while full:
  - With a pop in the same cycle: both occur, occupancy unchanged, no overflow.
  - Without a pop: the incoming row is discarded, `overflow` is set and stays 1 until `rst`, and FIFO contents are untouched.
- Pop while empty: ignored.
- Pointers wrap modulo `fifo_depth`.

**Tile counter.**
- `row_count` increments on every `row_valid`, whether the row was pushed or dropped.
- On the `m_rows`-th row, `row_count` wraps to 0 and `tile_done` pulses on the following cycle only.

**No arithmetic.** Sums pass through bit-exact; no truncation or sign handling.

## Timing

- **Reset values:** `out_valid=0`, `out_data=0`, `overflow=0`, `tile_done=0`, `row_count=0`. All delay-line and valid stages are cleared and pointers and count are zeroed.
- **Reset mid-operation:** any row partially inside the delay lines is discarded and never reaches the FIFO.
- **Latency:** with `in_valid` at edge E, the row is written at edge E+C-1. `out_valid` is high in the cycle after that edge if the FIFO was empty (C=16: edge E+15).
- **Pop timing:** a pop at edge P updates the head (or deasserts `out_valid`) immediately after P.
- **Throughput:** one row per cycle in; one row per cycle out with `out_ready` held high. Back-to-back `in_valid` is legal.
- **Handshake:** `out_valid` never drops without a pop or `rst`. `out_data` is stable while `out_valid && !out_ready`.
- **tile_done:** registered; high in the cycle after the edge that wrote (or dropped) the `m_rows`-th row.

## Test plan

All scenarios use the default parameters.

1. **Reset:** hold `rst=1` for 2 edges with random `in_sum` and `in_valid=1` → all outputs 0; no `out_valid` within 20 cycles after release with `in_valid=0`.
2. **Single row:** `in_valid` at edge 0, column j = j+1 at edge j, `out_ready=1` → `out_valid` high for exactly one cycle after edge 15; `out_data` column j = j+1 (column 15 = 16).
3. **Back-pressure and overflow:** 5 back-to-back rows (row r, every column = 100+r) with `out_ready=0` → after the 5th aligns, occupancy is 4 and `overflow=1`. Raising `out_ready` drains rows 100–103 in order; 104 never appears; `overflow` stays 1.
4. **Full plus simultaneous pop:** fill to 4, then pulse `out_ready` exactly on the edge the 5th row aligns → no overflow; drain order is rows 1–5.
5. **Tile counter:** 9 rows with `out_ready=1` → `tile_done` pulses once, the cycle after the 8th row's write edge. `row_count` reads 0 then 1 after the 9th.
6. **Reset mid-flight:** `in_valid` at edge 0, `rst` at edge 7 → `out_valid` never asserts; a fresh row after release appears normally at +15.

Source files
------------

// File: rtl/psum_deskew_drain.sv
// Drain stage below the last PE row: removes the per-column skew from partial sums,
// buffers aligned rows in a small FIFO and hands them out over valid/ready.
module psum_deskew_drain #(
  parameter int data_width         = 22,
  parameter int w_tile_column_size = 16,
  parameter int fifo_depth         = 4,
  parameter int m_rows             = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  input  logic [2*data_width*w_tile_column_size-1:0]   in_sum,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [2*data_width*w_tile_column_size-1:0]   out_data,
  output logic                                         overflow,
  output logic                                         tile_done,
  output logic [$clog2(m_rows)-1:0]                    row_count
);

  localparam int sum_w = 2 * data_width;
  localparam int cols  = w_tile_column_size;
  localparam int row_w = sum_w * cols;
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam int rc_w  = $clog2(m_rows);

  localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_depth);
  localparam logic [rc_w-1:0]  last_row   = rc_w'(m_rows - 1);

  logic [row_w-1:0] aligned;
  logic             row_valid;

  // ---------------------------------------------------------------------------
  // Deskew: column j waits (cols-1-j) cycles so every column lines up with the
  // last one, which is taken straight from the array.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < cols; j++) begin : g_col
    localparam int depth = cols - 1 - j;
    if (depth == 0) begin : g_direct
      assign aligned[j*sum_w +: sum_w] = in_sum[j*sum_w +: sum_w];
    end else begin : g_delay
      logic [sum_w-1:0] pipe [depth];

      // NOTE: sequential state uses non-blocking assignments so each stage
      // samples its neighbour's pre-edge value, giving a true shift register.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < depth; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= in_sum[j*sum_w +: sum_w];
          for (int k = 1; k < depth; k++) pipe[k] <= pipe[k-1];
        end
      end

      assign aligned[j*sum_w +: sum_w] = pipe[depth-1];
    end
  end

  // The valid flag follows column 0 through the full cols-1 delay.
  if (cols > 1) begin : g_vld
    logic [cols-2:0] vld_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= in_valid;
        for (int k = 1; k < cols - 1; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
    end

    assign row_valid = vld_pipe[cols-2];
  end else begin : g_vld_direct
    assign row_valid = in_valid;
  end

  // ---------------------------------------------------------------------------
  // Row FIFO
  // ---------------------------------------------------------------------------
  logic [row_w-1:0] mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] count;
  logic             full;
  logic             wr_en;
  logic             rd_en;
  logic             drop;

  assign full      = (count == full_count);
  assign out_valid = (count != '0);
  assign rd_en     = out_valid && out_ready;
  // A full FIFO still accepts a row when the head leaves on the same edge.
  assign wr_en     = row_valid && (!full || rd_en);
  assign drop      = row_valid && full && !rd_en;

  // NOTE: the storage array has no reset; occupancy is reset instead, and
  // out_data is gated below so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= aligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en) begin
        count <= count + 1'b1;
      end else if (rd_en && !wr_en) begin
        count <= count - 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // ---------------------------------------------------------------------------
  // Tile counter: counts every aligned row, kept or dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      row_count <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= row_valid && (row_count == last_row);
      if (row_valid) begin
        row_count <= (row_count == last_row) ? '0 : row_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_deskew_drain.sv
// Directed bench for psum_deskew_drain: skews rows the way the array does and
// checks alignment, FIFO ordering, overflow, tile counting and reset behaviour.
module tb_psum_deskew_drain;

  localparam int W  = 44;
  localparam int C  = 16;
  localparam int RW = W * C;

  typedef logic [RW-1:0] row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  row_t        in_sum;
  logic        out_valid;
  logic        out_ready;
  row_t        out_data;
  logic        overflow;
  logic        tile_done;
  logic [2:0]  row_count;

  int tests = 0;
  int fails = 0;

  row_t hist [C];
  logic hist_v [C];

  psum_deskew_drain #(
    .data_width(22),
    .w_tile_column_size(16),
    .fifo_depth(4),
    .m_rows(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_sum(in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .overflow(overflow),
    .tile_done(tile_done),
    .row_count(row_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input row_t obs, input row_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic row_t const_row(input int v);
    row_t r;
    for (int j = 0; j < C; j++) r[j*W +: W] = W'(v);
    return r;
  endfunction

  function automatic row_t ramp_row(input int base, input int step);
    row_t r;
    for (int j = 0; j < C; j++) r[j*W +: W] = W'(base + step * j);
    return r;
  endfunction

  // One clock: column j carries the row issued j cycles ago; unowned columns get noise.
  task automatic cycle(input logic v, input row_t row);
    row_t s;
    for (int k = C - 1; k > 0; k--) begin
      hist[k]   = hist[k-1];
      hist_v[k] = hist_v[k-1];
    end
    hist[0]   = row;
    hist_v[0] = v;
    s = rand_row();
    for (int j = 0; j < C; j++) begin
      if (hist_v[j]) s[j*W +: W] = hist[j][j*W +: W];
    end
    in_valid = v;
    in_sum   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rand_row());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < C; k++) begin
      hist_v[k] = 1'b0;
      hist[k]   = '0;
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;

    // 1. Reset with garbage and in_valid held high
    cycle(1'b1, rand_row());
    cycle(1'b1, rand_row());
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_tile_done", tile_done, 1'b0);
    check("rst_row_count", row_count, 3'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, rand_row());
      seen = seen | out_valid;
    end
    check("rst_no_valid_after_release", seen, 1'b0);

    // 2. Single row, column j = j+1
    out_ready = 1'b1;
    cycle(1'b1, ramp_row(1, 1));
    idle(14);
    check("single_not_yet_valid", out_valid, 1'b0);
    idle(1);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, ramp_row(1, 1));
    idle(1);
    check("single_valid_one_cycle", out_valid, 1'b0);
    check("single_data_gated", out_data, '0);
    check("single_row_count", row_count, 3'd1);

    // 3. Back-pressure: five rows into a four-deep FIFO
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) cycle(1'b1, const_row(100 + r));
    idle(14);
    check("bp_no_overflow_at_4", overflow, 1'b0);
    check("bp_head_at_4", out_data, const_row(100));
    idle(1);
    check("bp_overflow_set", overflow, 1'b1);
    check("bp_head_unchanged", out_data, const_row(100));
    check("bp_row_count", row_count, 3'd5);
    idle(3);
    check("bp_stable_while_stalled", out_data, const_row(100));
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check("bp_drain_valid", out_valid, 1'b1);
      check("bp_drain_data", out_data, const_row(100 + r));
      idle(1);
    end
    check("bp_drained_empty", out_valid, 1'b0);
    check("bp_overflow_sticky", overflow, 1'b1);

    // 4. Full FIFO with a pop on the same edge as the fifth write
    do_reset();
    out_ready = 1'b0;
    for (int r = 1; r <= 5; r++) cycle(1'b1, const_row(r));
    idle(14);
    check("fp_head_full", out_data, const_row(1));
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("fp_no_overflow", overflow, 1'b0);
    check("fp_head_after_pop", out_data, const_row(2));
    out_ready = 1'b1;
    for (int r = 2; r <= 5; r++) begin
      check("fp_drain_data", out_data, const_row(r));
      idle(1);
    end
    check("fp_drained_empty", out_valid, 1'b0);
    check("fp_overflow_final", overflow, 1'b0);

    // 5. Tile counter over nine rows
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 9; r++) cycle(1'b1, const_row(200 + r));
    idle(13);
    check("tile_before_8th", tile_done, 1'b0);
    check("tile_count_7", row_count, 3'd7);
    idle(1);
    check("tile_done_pulse", tile_done, 1'b1);
    check("tile_count_wrap", row_count, 3'd0);
    check("tile_head_row7", out_data, const_row(207));
    idle(1);
    check("tile_done_low", tile_done, 1'b0);
    check("tile_count_after_9th", row_count, 3'd1);
    check("tile_head_row8", out_data, const_row(208));
    idle(1);
    check("tile_done_stays_low", tile_done, 1'b0);

    // 6. Reset while a row is inside the delay lines
    do_reset();
    out_ready = 1'b1;
    cycle(1'b1, const_row(55));
    idle(6);
    rst = 1'b1;
    idle(1);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, rand_row());
      seen = seen | out_valid;
    end
    check("midrst_row_discarded", seen, 1'b0);
    cycle(1'b1, ramp_row(300, 3));
    idle(14);
    check("midrst_fresh_not_yet", out_valid, 1'b0);
    idle(1);
    check("midrst_fresh_valid", out_valid, 1'b1);
    check("midrst_fresh_data", out_data, ramp_row(300, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
